// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU function codes and sequencer state encodings
// for the 4-bit CPU fetch/decode/execute control.
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_OR   = 3'b100;

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_HALT   = 2'd3
   } state_t;

endpackage

// File: rtl/cpu_pc_reg.sv
// Program counter with load/increment/hold and natural modulo wrap.
// Load has priority over increment.
module cpu_pc_reg #(
   parameter int PC_WIDTH = 4,
   parameter int RESET_PC = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inc,
   input  logic                load,
   input  logic [PC_WIDTH-1:0] load_val,
   output logic [PC_WIDTH-1:0] pc
);

   logic [PC_WIDTH-1:0] pc_d;
   logic [PC_WIDTH-1:0] pc_q;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_val;
      end else if (inc) begin
         pc_d = pc_q + PC_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= PC_WIDTH'(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/cpu_fetch_ctrl.sv
// Fetch/decode/execute sequencer for the 4-bit CPU.
// Optional single-step control under CPU_FETCH_SINGLE_STEP_EN.
module cpu_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int PC_WIDTH    = 4,
   parameter int INSTR_WIDTH = 8,
   parameter int RESET_PC    = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   input  logic                   manual_mode,
   input  logic                   resume,
   input  logic                   zero_flag,
`ifdef CPU_FETCH_SINGLE_STEP_EN
   input  logic                   step,
   input  logic                   step_mode,
`endif
   input  logic [INSTR_WIDTH-1:0] instruction_in,
   output logic                   mux_sel,
   output logic [PC_WIDTH-1:0]    pc,
   output logic [INSTR_WIDTH-1:0] ir,
   output logic [2:0]             alu_op,
   output logic [3:0]             operand,
   output logic                   acc_we,
   output logic                   illegal,
   output logic                   halted
);

   state_t                 state_q, state_d;
   logic [INSTR_WIDTH-1:0] ir_q, ir_d;
   logic [2:0]             alu_op_q, alu_op_d;
   logic                   acc_we_q, acc_we_d;
   logic                   mux_sel_q, mux_sel_d;
   logic                   illegal_q, illegal_d;
   logic                   halted_q, halted_d;
   logic                   is_jmp_q, is_jmp_d;
   logic                   is_jz_q, is_jz_d;
   logic                   is_ill_q, is_ill_d;
   logic                   is_hlt_q, is_hlt_d;
   logic                   pc_inc;
   logic                   pc_load;
   logic                   fetch_go;
   logic [3:0]             opcode;

   assign opcode = ir_q[INSTR_WIDTH-1 -: 4];

`ifdef CPU_FETCH_SINGLE_STEP_EN
   logic step_q, step_d;

   always_comb begin
      step_d = step;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q <= 1'b0;
      end else begin
         step_q <= step_d;
      end
   end

   assign fetch_go = run & (~step_mode | (step & ~step_q));
`else
   assign fetch_go = run;
`endif

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      alu_op_d  = alu_op_q;
      acc_we_d  = 1'b0;
      mux_sel_d = mux_sel_q;
      illegal_d = illegal_q;
      halted_d  = halted_q;
      is_jmp_d  = is_jmp_q;
      is_jz_d   = is_jz_q;
      is_ill_d  = is_ill_q;
      is_hlt_d  = is_hlt_q;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            if (fetch_go) begin
               mux_sel_d = manual_mode;
               ir_d      = instruction_in;
               pc_inc    = ~manual_mode;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_op_d = ALU_PASS;
            is_jmp_d = 1'b0;
            is_jz_d  = 1'b0;
            is_ill_d = 1'b0;
            is_hlt_d = 1'b0;
            // acc_we is registered here so it is high for the EXECUTE cycle only
            unique case (opcode)
               OP_NOP: ;
               OP_LDI: begin alu_op_d = ALU_PASS; acc_we_d = 1'b1; end
               OP_ADD: begin alu_op_d = ALU_ADD;  acc_we_d = 1'b1; end
               OP_SUB: begin alu_op_d = ALU_SUB;  acc_we_d = 1'b1; end
               OP_AND: begin alu_op_d = ALU_AND;  acc_we_d = 1'b1; end
               OP_OR:  begin alu_op_d = ALU_OR;   acc_we_d = 1'b1; end
               OP_JMP: is_jmp_d = 1'b1;
               OP_JZ:  is_jz_d  = 1'b1;
               OP_HLT: is_hlt_d = 1'b1;
               default: is_ill_d = 1'b1;
            endcase
            state_d = S_EXEC;
         end
         S_EXEC: begin
            pc_load = is_jmp_q | (is_jz_q & zero_flag);
            if (is_ill_q) begin
               illegal_d = 1'b1;
            end
            if (is_hlt_q) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_HALT: begin
            if (resume) begin
               state_d  = S_FETCH;
               halted_d = 1'b0;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         alu_op_q  <= ALU_PASS;
         acc_we_q  <= 1'b0;
         mux_sel_q <= 1'b0;
         illegal_q <= 1'b0;
         halted_q  <= 1'b0;
         is_jmp_q  <= 1'b0;
         is_jz_q   <= 1'b0;
         is_ill_q  <= 1'b0;
         is_hlt_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         alu_op_q  <= alu_op_d;
         acc_we_q  <= acc_we_d;
         mux_sel_q <= mux_sel_d;
         illegal_q <= illegal_d;
         halted_q  <= halted_d;
         is_jmp_q  <= is_jmp_d;
         is_jz_q   <= is_jz_d;
         is_ill_q  <= is_ill_d;
         is_hlt_q  <= is_hlt_d;
      end
   end

   cpu_pc_reg #(
      .PC_WIDTH (PC_WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst      (rst),
      .inc      (pc_inc),
      .load     (pc_load),
      .load_val (PC_WIDTH'(ir_q[3:0])),
      .pc       (pc)
   );

   assign mux_sel = mux_sel_q;
   assign ir      = ir_q;
   assign alu_op  = alu_op_q;
   assign operand = ir_q[3:0];
   assign acc_we  = acc_we_q;
   assign illegal = illegal_q;
   assign halted  = halted_q;

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// Directed bench for cpu_fetch_ctrl: ROM program, jumps, stalls,
// illegal opcodes, mid-instruction reset, halt/resume, optional stepping.
module tb_cpu_fetch_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       manual_mode;
   logic       resume;
   logic       zero_flag;
   logic [7:0] instruction_in;
   logic       mux_sel;
   logic [3:0] pc;
   logic [7:0] ir;
   logic [2:0] alu_op;
   logic [3:0] operand;
   logic       acc_we;
   logic       illegal;
   logic       halted;
`ifdef CPU_FETCH_SINGLE_STEP_EN
   logic       step;
   logic       step_mode;
`endif

   logic [7:0] rom [16];
   logic [7:0] sw;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   // Bench-side 2:1 instruction mux: A = ROM at pc, B = switch bank
   assign instruction_in = mux_sel ? sw : rom[pc];

   cpu_fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .manual_mode    (manual_mode),
      .resume         (resume),
      .zero_flag      (zero_flag),
`ifdef CPU_FETCH_SINGLE_STEP_EN
      .step           (step),
      .step_mode      (step_mode),
`endif
      .instruction_in (instruction_in),
      .mux_sel        (mux_sel),
      .pc             (pc),
      .ir             (ir),
      .alu_op         (alu_op),
      .operand        (operand),
      .acc_we         (acc_we),
      .illegal        (illegal),
      .halted         (halted)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; manual_mode = 1'b0;
      resume = 1'b0; zero_flag = 1'b0; sw = 8'h00;
`ifdef CPU_FETCH_SINGLE_STEP_EN
      step = 1'b0; step_mode = 1'b0;
`endif
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      rom[0] = 8'h13; rom[1] = 8'h22; rom[2] = 8'hF0;

      #2;
      check("rst_pc", pc, 0);
      check("rst_ir", ir, 0);
      check("rst_acc_we", acc_we, 0);
      check("rst_mux_sel", mux_sel, 0);
      check("rst_illegal", illegal, 0);
      check("rst_halted", halted, 0);
      check("rst_alu_op", alu_op, 0);
      tick();
      rst = 1'b0; run = 1'b1;

      // Program 13 / 22 / F0
      tick(); check("p1_ir", ir, 8'h13); check("p1_pc", pc, 1);
      check("p1_fetch_we", acc_we, 0);
      tick(); check("p1_we", acc_we, 1); check("p1_alu", alu_op, 3'b000);
      check("p1_opnd", operand, 3);
      tick(); check("p1_we_off", acc_we, 0);
      tick(); check("p2_ir", ir, 8'h22); check("p2_pc", pc, 2);
      tick(); check("p2_we", acc_we, 1); check("p2_alu", alu_op, 3'b001);
      check("p2_opnd", operand, 2);
      tick(); check("p2_we_off", acc_we, 0);
      tick(); check("p3_ir", ir, 8'hF0); check("p3_pc", pc, 3);
      tick(); check("p3_not_halted", halted, 0);
      tick(); check("hlt_halted", halted, 1); check("hlt_pc", pc, 3);
      tick(3);
      check("hlt_hold_halted", halted, 1); check("hlt_hold_pc", pc, 3);
      check("hlt_hold_ir", ir, 8'hF0);

      rom[3] = 8'h6F; rom[0] = 8'h65; rom[5] = 8'h7A;
      rom[10] = 8'h7C; rom[11] = 8'h93; rom[12] = 8'h14; rom[13] = 8'h21;

      resume = 1'b1; tick(); resume = 1'b0;
      check("resume_halted", halted, 0); check("resume_pc", pc, 3);
      tick(); check("jf_ir", ir, 8'h6F); check("jf_pc", pc, 4);
      tick(2); check("jf_jump_pc", pc, 15);
      tick(); check("wrap_ir", ir, 8'h00); check("wrap_pc", pc, 0);
      tick(2);
      tick(); check("j5_ir", ir, 8'h65); check("j5_fetch_pc", pc, 1);
      tick(2); check("j5_pc", pc, 5);

      zero_flag = 1'b1;
      tick(); check("jz_t_ir", ir, 8'h7A); check("jz_t_fpc", pc, 6);
      tick(2); check("jz_taken_pc", pc, 10);
      zero_flag = 1'b0;
      tick(); check("jz_n_ir", ir, 8'h7C);
      tick(2); check("jz_not_pc", pc, 11);

      tick(); check("ill_ir", ir, 8'h93);
      tick(); check("ill_exec_we", acc_we, 0);
      check("ill_pre", illegal, 0);
      tick(); check("ill_set", illegal, 1);
      tick(); check("ldi4_ir", ir, 8'h14);
      tick(); check("ldi4_we", acc_we, 1); check("ldi4_opnd", operand, 4);
      check("ill_sticky", illegal, 1);
      tick();

      run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_pc", pc, 13); check("stall_ir", ir, 8'h14);
         check("stall_we", acc_we, 0);
      end
      run = 1'b1;
      tick(); check("post_stall_ir", ir, 8'h21);
      check("post_stall_pc", pc, 14);

      // Reset during DECODE of 0x21
      rst = 1'b1; #1;
      check("mid_rst_pc", pc, 0); check("mid_rst_ir", ir, 0);
      check("mid_rst_ill", illegal, 0); check("mid_rst_we", acc_we, 0);
      check("mid_rst_alu", alu_op, 0);
      tick(); check("mid_rst_no_we", acc_we, 0);
      rst = 1'b0;
      tick(); check("restart_ir", ir, 8'h65); check("restart_pc", pc, 1);
      tick(2); check("restart_j5", pc, 5);

      // Manual mode: first fetch still from ROM, pc held
      manual_mode = 1'b1; sw = 8'h63;
      tick(); check("man_ir", ir, 8'h7A); check("man_pc", pc, 5);
      check("man_mux", mux_sel, 1);
      tick(2); check("man_jz_pc", pc, 5);
      tick(); check("man_sw_ir", ir, 8'h63); check("man_sw_pc", pc, 5);
      tick(2); check("man_jmp_pc", pc, 3);
      sw = 8'hF0;
      tick(); check("man_hlt_ir", ir, 8'hF0);
      tick(2); check("man_halted", halted, 1);
      tick(2); check("man_hold_pc", pc, 3);

      rst = 1'b1; resume = 1'b1;
      tick();
      check("rst_res_pc", pc, 0); check("rst_res_ir", ir, 0);
      check("rst_res_mux", mux_sel, 0); check("rst_res_halted", halted, 0);
      rst = 1'b0; resume = 1'b0; manual_mode = 1'b0;

`ifdef CPU_FETCH_SINGLE_STEP_EN
      step_mode = 1'b1; step = 1'b0;
      tick(3); check("step_idle_pc", pc, 0); check("step_idle_ir", ir, 0);
      step = 1'b1;
      tick(); check("step1_ir", ir, 8'h65); check("step1_pc", pc, 1);
      tick(2); check("step1_jmp", pc, 5);
      tick(2); check("step_hold_pc", pc, 5); check("step_hold_ir", ir, 8'h65);
      step = 1'b0; tick();
      step = 1'b1;
      tick(); check("step2_ir", ir, 8'h7A); check("step2_pc", pc, 6);
      step_mode = 1'b0; step = 1'b0;
`endif

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_fetch_ctrl.md
Name: cpu_fetch_ctrl

Overview:
- Fetch/decode/execute sequencer for the 4-bit CPU.
- Sits directly downstream of the 8-bit instruction mux:
  - drives the mux select;
  - latches the selected instruction into the instruction register;
  - decodes it;
  - issues one-cycle execute strobes to the accumulator/ALU datapath.
- Owns the program counter and the halt state.

Parameters:
- PC_WIDTH, 4, program counter width; wraps modulo 2^PC_WIDTH.
- INSTR_WIDTH, 8, instruction width; upper 4 bits opcode, lower 4 bits operand.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level; 0 stalls the FSM in FETCH.
- manual_mode  input  1  1 = take instruction from switch bank (mux input B); 0 = program ROM (mux input A).
- resume  input  1  one-cycle pulse; leaves HALT.
- zero_flag  input  1  accumulator-zero flag from the datapath.
- instruction_in  input  INSTR_WIDTH  instruction from the 2:1 mux output.
- mux_sel  output  1  drives the instruction mux select.
- pc  output  PC_WIDTH  ROM address.
- ir  output  INSTR_WIDTH  instruction register.
- alu_op  output  3  ALU function code (valid while acc_we=1).
- operand  output  4  immediate = ir[3:0].
- acc_we  output  1  one-cycle accumulator write strobe.
- illegal  output  1  sticky; set on an undefined opcode.
- halted  output  1  1 while in HALT.

Behaviour:
- Reset (async, rst=1):
  - state=FETCH, pc=RESET_PC, ir=0, alu_op=0, acc_we=0, mux_sel=0, illegal=0, halted=0.
  - Takes effect immediately mid-instruction; the in-flight instruction is discarded with no strobe.
- States: FETCH -> DECODE -> EXECUTE -> FETCH; plus HALT. One instruction takes 3 cycles.
- FETCH:
  - run=0: hold; no register changes.
  - run=1:
    - mux_sel <= manual_mode;
    - ir <= instruction_in, sampled at the clock edge;
    - pc <= pc+1 only when manual_mode=0; wraps 2^PC_WIDTH-1 -> 0;
    - next state DECODE.
  - mux_sel is registered and used for the next FETCH. A manual_mode change therefore takes effect one instruction later.
- DECODE: decodes ir[7:4]; registers alu_op and the next-PC decision; next state EXECUTE.
- EXECUTE, per opcode:
  - 0x0 NOP: no action.
  - 0x1 LDI: alu_op=000 (pass B).
  - 0x2 ADD: alu_op=001.
  - 0x3 SUB: alu_op=010.
  - 0x4 AND: alu_op=011.
  - 0x5 OR: alu_op=100.
  - For 0x1–0x5, acc_we=1 for exactly this cycle.
  - 0x6 JMP: pc <= operand.
  - 0x7 JZ: pc <= operand if zero_flag=1 (sampled in EXECUTE); otherwise unchanged.
  - 0xF HLT: next state HALT, halted=1.
  - 0x8–0xE: treated as NOP, illegal <= 1 (sticky until reset).
  - Next state FETCH, except after HLT.
- acc_we is 0 in every state other than EXECUTE.
- HALT: pc and ir frozen.
  - resume=1 -> FETCH, halted=0.
  - run is ignored in HALT.
- Jump while manual_mode=1: pc is still updated.
- Simultaneous resume and rst: reset wins.

Optional Feature:
- Macro CPU_FETCH_SINGLE_STEP_EN.
- Defined:
  - adds input port step (1 bit) and input port step_mode (1 bit);
  - when step_mode=1, FETCH advances only on a cycle where run=1 and a rising edge of step is detected (internal registered edge detector, reset to 0);
  - one step executes exactly one full instruction.
- Undefined: no step ports; FETCH advances whenever run=1.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_NOP … OP_HLT;
  - ALU code localparams ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR;
  - FSM state encodings S_FETCH, S_DECODE, S_EXEC, S_HALT.
- One natural sub-module: cpu_pc_reg. Async-reset PC register with increment/load/hold controls and wrap.

Test Plan:
- Reset then run=1, manual_mode=0, ROM {0x13,0x22,0xF0}:
  - ir=0x13 after cycle 1;
  - acc_we pulses at cycles 3 and 6 with alu_op 000 then 001, operand 3 then 2;
  - halted=1 after cycle 9, pc=3.
- JMP wrap: pc=15 fetching 0x00 -> pc=0.
  - Then 0x65 -> pc=5 after its EXECUTE.
- JZ: 0x7A with zero_flag=1 -> pc=10; with zero_flag=0 -> pc = fetch address + 1.
- run=0 held 5 cycles in FETCH: pc, ir, state unchanged and acc_we=0.
  - Illegal opcode 0x9x -> illegal=1, persists through the following valid instructions, cleared only by rst.
- rst asserted in the DECODE cycle of 0x21:
  - all outputs immediately at reset values;
  - no acc_we pulse;
  - fetch restarts at RESET_PC.
- HALT then resume pulse -> FETCH next cycle, halted=0.
  - With CPU_FETCH_SINGLE_STEP_EN and step_mode=1: one step edge executes exactly one instruction (3 cycles), none without an edge.
